// File: rtl/muldiv.sv
// Iterative RISC-V style multiply/divide unit with a valid/ready handshake on both sides.
// Define MULDIV_FAST_MUL_EN to compute multiply ops in a single cycle.
module muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] out_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic             live_q;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] out_q, out_d;

  logic             sgn1, sgn2, neg1, neg2;
  logic [WIDTH-1:0] mag1, mag2;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] special_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] acc_n, lo_n;

  // hi/lo hold the product for multiplies, remainder/quotient magnitudes for divides.
  function automatic logic [WIDTH-1:0] finalize(input logic [2:0] op, input logic negq,
                                                input logic negr, input logic [WIDTH-1:0] hi,
                                                input logic [WIDTH-1:0] lo);
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res;
    prod = {hi, lo};
    if (negq) prod = -prod;
    if (!op[2]) begin
      res = (op[1:0] == 2'd0) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end else if (op[1]) begin
      res = negr ? -hi : hi;
    end else begin
      res = negq ? -lo : lo;
    end
    return res;
  endfunction

  always_comb begin
    sgn1        = op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'd1 || op_i[1:0] == 2'd2);
    sgn2        = op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'd1);
    neg1        = sgn1 & in1_i[WIDTH-1];
    neg2        = sgn2 & in2_i[WIDTH-1];
    mag1        = neg1 ? -in1_i : in1_i;
    mag2        = neg2 ? -in2_i : in2_i;
    div_zero    = (in2_i == '0);
    div_ovf     = ~op_i[0] && (in1_i == {1'b1, {(WIDTH-1){1'b0}}}) && (&in2_i);
    special_res = div_zero ? (op_i[1] ? in1_i : '1) : (op_i[1] ? '0 : in1_i);
  end

  // One shift-add multiply step and one restoring divide step on the shared registers.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opa_q});
    if (op_q[2]) begin
      acc_n = div_ge ? (div_shift[WIDTH-1:0] - opa_q) : div_shift[WIDTH-1:0];
      lo_n  = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      acc_n = mul_sum[WIDTH:1];
      lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    out_d   = out_q;
    unique case (state_q)
      StIdle: begin
        if (live_q && valid_i) begin
          op_d   = op_i;
          negq_d = neg1 ^ neg2;
          negr_d = op_i[2] & neg1;
          cnt_d  = '0;
          acc_d  = '0;
          if (op_i[2] && (div_zero || div_ovf)) begin
            state_d = StDone;
            out_d   = special_res;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!op_i[2]) begin
            state_d = StDone;
            out_d   = finalize(op_i, neg1 ^ neg2, 1'b0, fast_prod[2*WIDTH-1:WIDTH],
                               fast_prod[WIDTH-1:0]);
`endif
          end else begin
            state_d = StBusy;
            lo_d    = op_i[2] ? mag1 : mag2;
            opa_d   = op_i[2] ? mag2 : mag1;
          end
        end
      end
      StBusy: begin
        acc_d = acc_n;
        lo_d  = lo_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = StDone;
          out_d   = finalize(op_q, negq_q, negr_q, acc_n, lo_n);
        end
      end
      StDone: begin
        if (ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      live_q  <= 1'b0;
      op_q    <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      op_q    <= op_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      out_q   <= out_d;
    end
  end

  assign ready_o = live_q && (state_q == StIdle);
  assign valid_o = (state_q == StDone);
  assign out_o   = out_q;

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv (WIDTH=32): directed vectors, randomized ops against
// an arithmetic reference model, handshake hold and mid-operation reset.
module tb_muldiv;

  localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = W + 1;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         valid_in = 1'b0;
  logic         ready_out;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         valid_out;
  logic         ready_in = 1'b0;
  logic [W-1:0] out;

  int tests = 0;
  int failed = 0;

  muldiv #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .valid_i   (valid_in),
    .ready_o   (ready_out),
    .op_i      (op),
    .in1_i     (in1),
    .in2_i     (in2),
    .valid_o   (valid_out),
    .ready_i   (ready_in),
    .out_o     (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // Reference: full-precision signed arithmetic, then pick the architectural result.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic signed [2*W+1:0] x, y, p;
    int sa, sb;
    if (!o[2]) begin
      x = (o == 3'd1 || o == 3'd2) ? {{(W+2){a[W-1]}}, a} : {{(W+2){1'b0}}, a};
      y = (o == 3'd1) ? {{(W+2){b[W-1]}}, b} : {{(W+2){1'b0}}, b};
      p = x * y;
      return (o == 3'd0) ? p[W-1:0] : p[2*W-1:W];
    end
    if (b == 0) return o[1] ? a : '1;
    if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? '0 : a;
      sa = a;
      sb = b;
      return o[1] ? W'(sa % sb) : W'(sa / sb);
    end
    return o[1] ? a % b : a / b;
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    if (!o[2]) return MulLat;
    if (b == 0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return W + 1;
  endfunction

  // Present a request at a negedge; the following posedge accepts it.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    check("ready_before_accept", 64'(ready_out), 64'd1);
    op = o;
    in1 = a;
    in2 = b;
    valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    in1 = $urandom;
    in2 = $urandom;
  endtask

  // Called at the first negedge after accept; returns cycles until valid_o.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!valid_out && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int lat;
    logic [W-1:0] exp;
    exp = model(o, a, b);
    issue(o, a, b);
    wait_done(lat);
    check({tag, "_valid"}, 64'(valid_out), 64'd1);
    check({tag, "_result"}, 64'(out), 64'(exp));
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat(o, a, b)));
    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
    check({tag, "_idle_after"}, 64'({ready_out, valid_out}), 64'b10);
    check({tag, "_held"}, 64'(out), 64'(exp));
  endtask

  initial begin
    logic [2:0]   o;
    logic [W-1:0] a, b, held;
    int           lat;
    bit           seen;

    // Reset state
    #12;
    check("rst_ready", 64'(ready_out), 64'd0);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    check("ready_low_until_edge", 64'(ready_out), 64'd0);
    @(negedge clk);
    check("ready_after_edge", 64'(ready_out), 64'd1);

    // Directed vectors
    run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD);
    check("mul_7_m3_const", 64'(out), 64'hFFFF_FFEB);
    run_op("mulhu_ones", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhu_ones_const", 64'(out), 64'hFFFF_FFFE);
    run_op("mulh_ones", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulh_ones_const", 64'(out), 64'h0);
    run_op("mulhsu_m1_2", 3'd2, 32'hFFFF_FFFF, 32'd2);
    check("mulhsu_m1_2_const", 64'(out), 64'hFFFF_FFFF);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2_const", 64'(out), 64'hFFFF_FFFD);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    check("rem_m7_2_const", 64'(out), 64'hFFFF_FFFF);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7);
    check("divu_100_7_const", 64'(out), 64'd14);
    run_op("divu_by0", 3'd5, 32'd5, 32'd0);
    check("divu_by0_const", 64'(out), 64'hFFFF_FFFF);
    run_op("remu_by0", 3'd7, 32'd5, 32'd0);
    check("remu_by0_const", 64'(out), 64'd5);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_const", 64'(out), 64'h8000_0000);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_by0", 3'd4, 32'hFFFF_FF00, 32'd0);
    run_op("rem_by0", 3'd6, 32'hFFFF_FF00, 32'd0);

    // Randomized ops, biased towards corner operands
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      run_op("rand", o, a, b);
    end

    // Hold in DONE with ready_i low; valid_i pulses must be ignored
    issue(3'd5, 32'd1000, 32'd7);
    wait_done(lat);
    check("hold_reach_done", 64'(valid_out), 64'd1);
    held = out;
    check("hold_value", 64'(held), 64'd142);
    for (int i = 0; i < 10; i++) begin
      valid_in = i[0];
      op = 3'd0;
      in1 = $urandom;
      in2 = $urandom;
      @(negedge clk);
      check("hold_valid", 64'(valid_out), 64'd1);
      check("hold_out", 64'(out), 64'(held));
      check("hold_ready", 64'(ready_out), 64'd0);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
    check("hold_release", 64'({ready_out, valid_out}), 64'b10);
    check("hold_out_kept", 64'(out), 64'(held));

    // Reset during BUSY iteration 5
    issue(3'd5, 32'd123456, 32'd11);
    repeat (4) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_valid", 64'(valid_out), 64'd0);
    check("midrst_out", 64'(out), 64'd0);
    check("midrst_ready", 64'(ready_out), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (valid_out) seen = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_result", 64'(seen), 64'd0);
    run_op("post_rst_divu_9_3", 3'd5, 32'd9, 32'd3);
    check("post_rst_divu_const", 64'(out), 64'd3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 The parameter SHALL be: WIDTH, default 32, operand/result width in bits (legal values: even integers 8..64).
REQ-002 Port clk_i  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 Port reset_n_i  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 Port valid_i  input  1  SHALL flag a valid request on op_i/in1_i/in2_i.
REQ-005 Port ready_o  output  1  SHALL flag that a request can be accepted this cycle.
REQ-006 Port op_i  input  3  SHALL select 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 Ports in1_i, in2_i  input  WIDTH  SHALL be dividend/multiplicand and divisor/multiplier.
REQ-008 Port valid_o  output  1  SHALL flag a valid result on out_o.
REQ-009 Port ready_i  input  1  SHALL flag that the consumer takes the result this cycle.
REQ-010 Port out_o  output  WIDTH  SHALL carry the result.

Function
REQ-011 States SHALL be IDLE, BUSY, DONE; ready_o = 1 only in IDLE; valid_o = 1 only in DONE.
REQ-012 Accept SHALL occur on a rising edge with IDLE and valid_i = 1; operands and op are registered; inputs are ignored outside IDLE.
REQ-013 On accept of a normal op, FSM SHALL go IDLE->BUSY, run exactly WIDTH iterations (one per cycle), then go to DONE; valid_o rises WIDTH+1 cycles after the accept edge.
REQ-014 Multiply SHALL use shift-add on operand magnitudes with a 2*WIDTH-bit product, negated at the end when signs differ; MUL returns the low WIDTH bits, MULH/MULHSU/MULHU the high WIDTH bits.
REQ-015 Signedness SHALL be: MULH both signed, MULHSU in1 signed and in2 unsigned, MULHU both unsigned; DIV/REM signed, DIVU/REMU unsigned.
REQ-016 Divide SHALL be restoring on magnitudes; quotient sign = sign(in1) XOR sign(in2); remainder sign = sign(in1); quotient truncates toward zero.
REQ-017 Divide by zero SHALL skip BUSY (IDLE->DONE in one cycle), returning all-ones for DIV/DIVU and in1 for REM/REMU.
REQ-018 Signed overflow (in1 = most-negative, in2 = all-ones, op DIV/REM) SHALL skip BUSY, returning in1 for DIV and 0 for REM.
REQ-019 DONE SHALL hold valid_o and out_o stable until ready_i = 1, then go to IDLE; a new request is accepted no earlier than the following cycle.
REQ-020 While valid_o = 1, out_o SHALL not change; otherwise out_o SHALL hold the last result.
REQ-021 All arithmetic SHALL be modulo 2^WIDTH on results; internal accumulators are wide enough that no iteration overflows.

Reset
REQ-022 Asserting reset_n_i = 0 SHALL immediately force state IDLE, ready_o = 0 while asserted, valid_o = 0, out_o = 0, and clear all operand/iteration registers.
REQ-023 Reset asserted mid-operation (BUSY or DONE) SHALL abandon the operation with no result ever presented.
REQ-024 ready_o SHALL rise on the first rising clock edge after reset_n_i deasserts.

Configuration
REQ-025 Macro MULDIV_FAST_MUL_EN defined: multiply ops (0-3) SHALL compute in a single cycle (IDLE->DONE, valid_o one cycle after accept); divide ops are unchanged.
REQ-026 Macro MULDIV_FAST_MUL_EN undefined: multiply ops SHALL use the iterative path of REQ-013; results are bit-identical in both builds.

Verification
REQ-027 WIDTH=32, op MUL, in1=7, in2=-3 (0xFFFFFFFD) -> out_o=0xFFFFFFEB, valid_o exactly 33 cycles after accept (1 cycle with MULDIV_FAST_MUL_EN).
REQ-028 op MULHU, in1=in2=0xFFFFFFFF -> 0xFFFFFFFE; op MULH, same operands -> 0x00000000; op MULHSU, in1=0xFFFFFFFF, in2=2 -> 0xFFFFFFFF.
REQ-029 op DIV, in1=-7, in2=2 -> 0xFFFFFFFD; op REM, same operands -> 0xFFFFFFFF; op DIVU, in1=100, in2=7 -> 14.
REQ-030 op DIVU, in2=0, in1=5 -> 0xFFFFFFFF; op REMU, in2=0, in1=5 -> 5; op DIV, in1=0x80000000, in2=0xFFFFFFFF -> 0x80000000; all three with valid_o 1 cycle after accept.
REQ-031 Hold ready_i=0 for 10 cycles in DONE -> valid_o and out_o stable, ready_o=0, and valid_i pulses ignored; ready_i=1 -> IDLE the next cycle.
REQ-032 Pull reset_n_i low at BUSY iteration 5 -> valid_o=0, out_o=0 immediately; after release, a fresh DIVU 9/3 -> 3 with normal latency.
